// File: rtl/ethernet_pt_dbg_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory controller.
// The strobe priority is held in one constant so every user agrees on it.
package ethernet_pt_dbg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_JRD,
      ST_JCAP,
      ST_JWR,
      ST_CRD
   } ocimem_state_e;

   localparam int DATA_W      = 32;
   localparam int JDO_W       = 38;
   localparam int ADDR_LSB    = 10;
   localparam int DATA_LSB    = 3;
   localparam int RDAFTER_BIT = 25;
   localparam int CLRERR_BIT  = 24;

   typedef enum logic [1:0] {
      STB_NONE,
      STB_B,
      STB_A,
      STB_N
   } strobe_e;

   // Highest priority in the top field, lowest in the bottom field.
   localparam logic [5:0] STROBE_PRIO = {STB_B, STB_A, STB_N};

   function automatic strobe_e pick_strobe(input logic stb_b, input logic stb_a,
                                           input logic stb_n);
      logic [3:0] req;
      strobe_e    sel;
      strobe_e    cand;
      req = {stb_n, stb_a, stb_b, 1'b0};
      sel = STB_NONE;
      for (int i = 0; i < 3; i++) begin
         cand = strobe_e'(STROBE_PRIO[2*i +: 2]);
         if (req[cand]) sel = cand;
      end
      return sel;
   endfunction

endpackage

// File: rtl/ethernet_pt_dbg_ocimem_ram.sv
// Single-port synchronous debug RAM, read-first, one cycle read latency.
// Contents are deliberately not reset.
module ethernet_pt_dbg_ocimem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ethernet_pt_dbg_ocimem_ctrl.sv
// OCI debug-memory controller: arbitrates the shared debug RAM between the
// JTAG ocimem strobes and the CPU Avalon-MM slave, JTAG always winning.
module ethernet_pt_dbg_ocimem_ctrl
   import ethernet_pt_dbg_pkg::*;
#(
   parameter int          ADDR_W        = 8,
   parameter logic [31:0] RESET_MONDREG = 32'h0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output ocimem_state_e     dbg_state,
   output logic [ADDR_W-1:0] dbg_mon_areg
);

   ocimem_state_e       state;
   logic [ADDR_W-1:0]   mon_areg;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   readdata_q;
   logic [DATA_W-1:0]   ram_dout;
   logic [DATA_W-1:0]   ram_wdata;
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_we;
   logic                any_strobe;
   logic                cpu_wr_go;
   logic                cpu_rd_go;
   strobe_e             stb_sel;
   logic                unused_jdo;

   assign unused_jdo = ^{jdo[JDO_W-1:DATA_LSB+DATA_W], jdo[DATA_LSB-1:0]};

   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign stb_sel    = pick_strobe(take_action_ocimem_b, take_action_ocimem_a,
                                   take_no_action_ocimem_a);
   assign cpu_wr_go  = reset_n && (state == ST_IDLE) && !any_strobe && avs_write;
   assign cpu_rd_go  = (state == ST_IDLE) && !any_strobe && avs_read && !avs_write;

   // Avalon handshake: a CPU command is accepted on the clk edge at which
   // avs_waitrequest is low; the master holds command, address and data until then.
   // A read is stalled for its issue cycle and completes in ST_CRD.
   assign avs_waitrequest = !reset_n
                          || ((state != ST_IDLE) && (state != ST_CRD))
                          || ((state == ST_IDLE) && (any_strobe || cpu_rd_go));

   assign avs_readdata = (state == ST_CRD) ? ram_dout : readdata_q;
   assign dbg_state    = state;
   assign dbg_mon_areg = mon_areg;

   always_comb begin
      ram_addr  = avs_address;
      ram_we    = 1'b0;
      ram_wdata = avs_writedata;
      if (state == ST_JWR) begin
         ram_addr  = mon_areg;
         ram_we    = 1'b1;
         ram_wdata = wdata_q;
      end else if (state == ST_JRD) begin
         ram_addr = mon_areg;
      end else if (cpu_wr_go) begin
         ram_we = 1'b1;
      end
   end

   ethernet_pt_dbg_ocimem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_dout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         mon_areg      <= '0;
         wdata_q       <= '0;
         readdata_q    <= '0;
         MonDReg       <= RESET_MONDREG;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               case (stb_sel)
                  STB_B: begin
                     wdata_q       <= jdo[DATA_LSB +: DATA_W];
                     monitor_ready <= 1'b0;
                     state         <= ST_JWR;
                  end
                  STB_A: begin
                     mon_areg      <= jdo[ADDR_LSB +: ADDR_W];
                     monitor_ready <= 1'b0;
                     if (jdo[CLRERR_BIT])  monitor_error <= 1'b0;
                     if (jdo[RDAFTER_BIT]) state <= ST_JRD;
                  end
                  STB_N: begin
                     monitor_ready <= 1'b0;
                     state         <= ST_JRD;
                  end
                  default: begin
                     // An address load without read-after finishes here.
                     monitor_ready <= 1'b1;
                     if (cpu_rd_go) state <= ST_CRD;
                  end
               endcase
            end
            ST_JWR: begin
               mon_areg      <= mon_areg + 1'b1;
               monitor_ready <= 1'b1;
               state         <= ST_IDLE;
            end
            ST_JRD: state <= ST_JCAP;
            ST_JCAP: begin
               MonDReg       <= ram_dout;
               mon_areg      <= mon_areg + 1'b1;
               monitor_ready <= 1'b1;
               state         <= ST_IDLE;
            end
            ST_CRD: begin
               readdata_q <= ram_dout;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if ((state != ST_IDLE) && any_strobe) monitor_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ethernet_pt_dbg_ocimem_ctrl.sv
// Bench for the OCI debug-memory controller: directed scenarios with literal
// expectations, then randomized JTAG/CPU traffic against a latency-count model.
module tb_ethernet_pt_dbg_ocimem_ctrl;
   import ethernet_pt_dbg_pkg::*;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [37:0]   jdo = '0;
   logic          take_action_ocimem_a = 1'b0;
   logic          take_action_ocimem_b = 1'b0;
   logic          take_no_action_ocimem_a = 1'b0;
   logic [AW-1:0] avs_address = '0;
   logic          avs_read = 1'b0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [31:0]   avs_readdata;
   logic          avs_waitrequest;
   logic [31:0]   MonDReg;
   logic          monitor_ready;
   logic          monitor_error;
   ocimem_state_e dbg_state;
   logic [AW-1:0] dbg_mon_areg;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;
   logic        wr_seen = 1'b1;
   logic [31:0] rd_seen = '0;

   ethernet_pt_dbg_ocimem_ctrl #(.ADDR_W(AW), .RESET_MONDREG(32'h0)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .dbg_state               (dbg_state),
      .dbg_mon_areg            (dbg_mon_areg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A JTAG op occupies a fixed number of edges after its strobe (write 1,
   // read 2); its effect lands on the last one. A CPU read takes one extra edge.
   logic [31:0] m_mem [256];
   bit          m_vld [256];
   int          m_jt_left = 0;
   bit          m_jt_wr = 0;
   logic [31:0] m_jt_data = '0;
   bit          m_crd = 0;
   logic [31:0] m_rd_data = '0;
   bit          m_rd_known = 0;
   logic [7:0]  m_areg = '0;
   logic [31:0] m_dreg = '0;
   bit          m_dreg_known = 1;
   bit          m_ready = 1;
   bit          m_err = 0;

   task automatic model_step();
      bit any_stb;
      any_stb = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
      if (m_jt_left > 0) begin
         if (any_stb) m_err = 1;
         m_jt_left--;
         if (m_jt_left == 0) begin
            if (m_jt_wr) begin
               m_mem[m_areg] = m_jt_data;
               m_vld[m_areg] = 1;
            end else begin
               m_dreg       = m_mem[m_areg];
               m_dreg_known = m_vld[m_areg];
            end
            m_areg  = m_areg + 8'd1;
            m_ready = 1;
         end
      end else if (m_crd) begin
         if (any_stb) m_err = 1;
         m_crd = 0;
      end else if (any_stb) begin
         m_ready = 0;
         if (take_action_ocimem_b) begin
            m_jt_wr   = 1;
            m_jt_data = jdo[34:3];
            m_jt_left = 1;
         end else if (take_action_ocimem_a) begin
            m_areg = jdo[17:10];
            if (jdo[24]) m_err = 0;
            if (jdo[25]) begin
               m_jt_wr   = 0;
               m_jt_left = 2;
            end
         end else begin
            m_jt_wr   = 0;
            m_jt_left = 2;
         end
      end else begin
         m_ready = 1;
         if (avs_write) begin
            m_mem[avs_address] = avs_writedata;
            m_vld[avs_address] = 1;
         end else if (avs_read) begin
            m_crd      = 1;
            m_rd_data  = m_mem[avs_address];
            m_rd_known = m_vld[avs_address];
         end
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_jt_left    = 0;
         m_crd        = 0;
         m_areg       = '0;
         m_dreg       = 32'h0;
         m_dreg_known = 1;
         m_ready      = 1;
         m_err        = 0;
      end else begin
         model_step();
      end
   end

   function automatic logic exp_waitreq();
      if (!reset_n) return 1'b1;
      if (m_jt_left > 0) return 1'b1;
      if (m_crd) return 1'b0;
      return take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a
             | (avs_read & ~avs_write);
   endfunction

   // ---------------- scoreboard compare (every cycle, mid-cycle) ----------------
   always @(negedge clk) begin
      wr_seen <= avs_waitrequest;
      rd_seen <= avs_readdata;
      if (cmp_en) begin
         chk("waitrequest", avs_waitrequest, exp_waitreq());
         chk("monitor_ready", monitor_ready, m_ready);
         chk("monitor_error", monitor_error, m_err);
         chk("mon_areg", dbg_mon_areg, m_areg);
         chk("fsm_idle", dbg_state == ST_IDLE, (m_jt_left == 0) && !m_crd);
         if (m_dreg_known) chk("MonDReg", MonDReg, m_dreg);
         if (reset_n && m_crd && m_rd_known) chk("avs_readdata", avs_readdata, m_rd_data);
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [37:0] jdo_addr(input logic [7:0] a, input bit rdafter, input bit clr);
      logic [37:0] j;
      j = '0;
      j[17:10] = a;
      j[25] = rdafter;
      j[24] = clr;
      return j;
   endfunction

   function automatic logic [37:0] jdo_data(input logic [31:0] d);
      logic [37:0] j;
      j = '0;
      j[34:3] = d;
      return j;
   endfunction

   // kind: 1 = ocimem_a, 2 = ocimem_b, 3 = no_action_a
   task automatic drive_jtag(input int kind, input logic [37:0] j);
      jdo = j;
      take_action_ocimem_a    = (kind == 1);
      take_action_ocimem_b    = (kind == 2);
      take_no_action_ocimem_a = (kind == 3);
      tick();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !monitor_ready; i++) tick();
      chk("ready_wait", monitor_ready, 1'b1);
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (!wr_seen) break;
      end
      chk("cpu_write_accept", wr_seen, 1'b0);
      #1;
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
      avs_address = a;
      avs_read    = 1'b1;
      waits       = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (!wr_seen) break;
         waits++;
      end
      chk("cpu_read_accept", wr_seen, 1'b0);
      d = rd_seen;
      #1;
      avs_read = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic [31:0] rdat;
   int          rwaits;
   bit          cpu_act;
   int          sv;
   int          k;
   logic [37:0] rj;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1;
      @(negedge clk);
      chk("rst_waitreq", avs_waitrequest, 1'b1);
      chk("rst_ready", monitor_ready, 1'b1);
      chk("rst_error", monitor_error, 1'b0);
      chk("rst_mondreg", MonDReg, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      chk("post_rst_ready", monitor_ready, 1'b1);
      chk("post_rst_error", monitor_error, 1'b0);
      chk("post_rst_mondreg", MonDReg, 32'h0);
      chk("post_rst_waitreq", avs_waitrequest, 1'b0);

      // Known contents for low addresses.
      cpu_write(8'h00, 32'hA5A50000);
      for (int i = 1; i < 16; i++) cpu_write(8'(i), $urandom);

      // Load, write, read back through JTAG.
      drive_jtag(1, jdo_addr(8'h10, 0, 0));
      wait_ready();
      drive_jtag(2, jdo_data(32'hDEADBEEF));
      wait_ready();
      drive_jtag(1, jdo_addr(8'h10, 1, 0));
      chk("s1_ready_jrd", monitor_ready, 1'b0);
      tick();
      chk("s1_ready_jcap", monitor_ready, 1'b0);
      tick();
      chk("s1_mondreg", MonDReg, 32'hDEADBEEF);
      chk("s1_areg", dbg_mon_areg, 8'h11);
      chk("s1_ready_done", monitor_ready, 1'b1);
      chk("s1_model_dreg", m_dreg, 32'hDEADBEEF);

      // Address wrap at the top of the RAM.
      drive_jtag(1, jdo_addr(8'hFF, 0, 0));
      wait_ready();
      drive_jtag(2, jdo_data(32'h00000001));
      wait_ready();
      chk("s2_areg_wrap", dbg_mon_areg, 8'h00);
      drive_jtag(3, '0);
      tick();
      tick();
      chk("s2_mondreg", MonDReg, 32'hA5A50000);
      chk("s2_areg", dbg_mon_areg, 8'h01);
      cpu_read(8'hFF, rdat, rwaits);
      chk("s2_cpu_ff", rdat, 32'h00000001);

      // CPU read colliding with a JTAG write to the same word.
      drive_jtag(1, jdo_addr(8'h20, 0, 0));
      wait_ready();
      fork
         drive_jtag(2, jdo_data(32'h12345678));
         cpu_read(8'h20, rdat, rwaits);
      join
      chk("s3_cpu_data", rdat, 32'h12345678);
      chk("s3_waits", rwaits, 32'd3);
      chk("s3_areg", dbg_mon_areg, 8'h21);

      // Strobe during JCAP is dropped and flags an error; clear via jdo[24].
      drive_jtag(1, jdo_addr(8'h10, 0, 0));
      wait_ready();
      drive_jtag(3, '0);
      tick();
      drive_jtag(2, jdo_data(32'hBAD0BAD0));
      chk("s4_error_set", monitor_error, 1'b1);
      chk("s4_mondreg", MonDReg, 32'hDEADBEEF);
      chk("s4_idle", dbg_state == ST_IDLE, 1'b1);
      tick();
      chk("s4_error_sticky", monitor_error, 1'b1);
      drive_jtag(1, jdo_addr(8'h10, 0, 1));
      chk("s4_error_clr", monitor_error, 1'b0);
      wait_ready();

      // Asynchronous reset in the middle of a JTAG read.
      cpu_write(8'h30, 32'hCAFEF00D);
      drive_jtag(1, jdo_addr(8'h30, 1, 0));
      #2;
      reset_n = 1'b0;
      #1;
      chk("s5_ready", monitor_ready, 1'b1);
      chk("s5_mondreg", MonDReg, 32'h0);
      chk("s5_idle", dbg_state == ST_IDLE, 1'b1);
      chk("s5_waitreq", avs_waitrequest, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      cpu_read(8'h30, rdat, rwaits);
      chk("s5_ram_kept", rdat, 32'hCAFEF00D);

      // Randomized mixed traffic.
      cpu_act = 0;
      for (int c = 0; c < 3000; c++) begin
         if (cpu_act && !wr_seen) begin
            cpu_act   = 0;
            avs_read  = 1'b0;
            avs_write = 1'b0;
         end
         if (!cpu_act && $urandom_range(0, 99) < 35) begin
            cpu_act       = 1;
            k             = $urandom_range(0, 5);
            avs_write     = (k <= 2);
            avs_read      = (k >= 2);
            avs_address   = 8'($urandom_range(0, 15));
            avs_writedata = $urandom;
         end
         sv = $urandom_range(0, 99);
         take_action_ocimem_b    = (sv < 6);
         take_action_ocimem_a    = (sv >= 4) && (sv < 12);
         take_no_action_ocimem_a = (sv >= 10) && (sv < 16);
         rj = {$urandom, $urandom};
         rj[17:10] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
         rj[25] = ($urandom_range(0, 1) == 1);
         rj[24] = ($urandom_range(0, 3) == 0);
         jdo = rj;
         tick();
      end
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      avs_read  = 1'b0;
      avs_write = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
